// File: rtl/sync_bit_edge_filter.sv
// sync_bit_edge_filter
//   Destination-domain consumer of a bit synchronizer. Rejects pulses shorter
//   than FILT_LEN consecutive samples, keeps a filtered LEVEL, and reports each
//   committed transition as a rise/fall event through a one-entry valid/ready
//   buffer. A sticky OVF flag records events dropped because the buffer was full.
//
//   Optional feature: define SYNC_EDGE_CNT_EN to add a 16-bit wrapping
//   committed-edge counter on EVT_CNT.
//
// Parameters
//   INIT      reset value of LEVEL (match the synchronizer's init)
//   FILT_W    width of FILT_LEN / qualification counter
// Ports
//   CLK, RST_N        clock, async active-low reset
//   D_IN              synchronized input level
//   EN                filter enable (low: no commits, qualification cleared)
//   FILT_LEN          required consecutive differing samples (0 acts as 1)
//   LEVEL             filtered level
//   EVT_VALID/EVT_RISE/EVT_READY  event buffer handshake, 1 = rise
//   OVF, OVF_CLR      sticky drop flag and its clear (set wins)
//   EVT_CNT           committed-edge count (SYNC_EDGE_CNT_EN only)

module sync_bit_edge_filter #(
    parameter logic INIT   = 1'b0,
    parameter int   FILT_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              D_IN,
    input  logic              EN,
    input  logic [FILT_W-1:0] FILT_LEN,
    output logic              LEVEL,
    output logic              EVT_VALID,
    output logic              EVT_RISE,
    input  logic              EVT_READY,
    output logic              OVF,
    input  logic              OVF_CLR
`ifdef SYNC_EDGE_CNT_EN
    ,
    output logic [15:0]       EVT_CNT
`endif
);

    localparam int CW = FILT_W + 1;

    typedef enum logic {ST_STABLE = 1'b0, ST_QUAL = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_eff;
    logic [CW-1:0]   cnt_inc;
    logic            commit;
    logic            level_q, level_d;
    logic            evt_valid_q, evt_valid_d;
    logic            evt_rise_q, evt_rise_d;
    logic            ovf_q, ovf_d;
    logic            ovf_set;

    // A programmed length of 0 behaves exactly like 1.
    assign len_eff = (FILT_LEN == '0) ? CW'(1) : {1'b0, FILT_LEN};
    assign cnt_inc = cnt_q + CW'(1);

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_STABLE;
            cnt_q       <= '0;
            level_q     <= INIT;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            evt_valid_q <= evt_valid_d;
            evt_rise_q  <= evt_rise_d;
            ovf_q       <= ovf_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic: qualification of a differing input
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!EN) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_STABLE: begin
                    if (D_IN != level_q) begin
                        if (len_eff == CW'(1)) begin
                            commit = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            state_d = ST_QUAL;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_QUAL: begin
                    if (D_IN == level_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= len_eff) begin
                        // >= rather than == so a length lowered mid-qualification
                        // commits on the next differing sample.
                        commit  = 1'b1;
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Output logic: level, event buffer, overflow
    // ---------------------------------------------------------------
    always_comb begin
        level_d     = commit ? D_IN : level_q;
        evt_valid_d = evt_valid_q;
        evt_rise_d  = evt_rise_q;
        ovf_set     = 1'b0;
        if (commit) begin
            // Load when empty or when the held event leaves on this edge.
            if (!evt_valid_q || EVT_READY) begin
                evt_valid_d = 1'b1;
                evt_rise_d  = D_IN;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (evt_valid_q && EVT_READY) begin
            evt_valid_d = 1'b0;
        end
        ovf_d = ovf_set | (ovf_q & ~OVF_CLR);
    end

    assign LEVEL     = level_q;
    assign EVT_VALID = evt_valid_q;
    assign EVT_RISE  = evt_rise_q;
    assign OVF       = ovf_q;

`ifdef SYNC_EDGE_CNT_EN
    logic [15:0] evt_cnt_q, evt_cnt_d;

    // Counts every commit, including ones whose event was dropped.
    always_comb begin
        evt_cnt_d = evt_cnt_q + {15'd0, commit};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) evt_cnt_q <= '0;
        else        evt_cnt_q <= evt_cnt_d;
    end

    assign EVT_CNT = evt_cnt_q;
`endif

endmodule

// File: tb/tb_sync_bit_edge_filter.sv
module tb_sync_bit_edge_filter;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       D_IN = 1'b0;
    logic       EN = 1'b0;
    logic [3:0] FILT_LEN = 4'd0;
    logic       LEVEL, EVT_VALID, EVT_RISE, OVF;
    logic       EVT_READY = 1'b0;
    logic       OVF_CLR = 1'b0;
    // second instance only checks INIT=1
    logic       LEVEL1, EVT_VALID1, EVT_RISE1, OVF1;
    logic       D_IN1 = 1'b1;
`ifdef SYNC_EDGE_CNT_EN
    logic [15:0] EVT_CNT, EVT_CNT1;
`endif

    always #5 CLK = ~CLK;

    sync_bit_edge_filter #(.INIT(1'b0), .FILT_W(4)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .EN(EN), .FILT_LEN(FILT_LEN),
        .LEVEL(LEVEL), .EVT_VALID(EVT_VALID), .EVT_RISE(EVT_RISE),
        .EVT_READY(EVT_READY), .OVF(OVF), .OVF_CLR(OVF_CLR)
`ifdef SYNC_EDGE_CNT_EN
        , .EVT_CNT(EVT_CNT)
`endif
    );

    sync_bit_edge_filter #(.INIT(1'b1), .FILT_W(4)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN1), .EN(EN), .FILT_LEN(FILT_LEN),
        .LEVEL(LEVEL1), .EVT_VALID(EVT_VALID1), .EVT_RISE(EVT_RISE1),
        .EVT_READY(EVT_READY), .OVF(OVF1), .OVF_CLR(OVF_CLR)
`ifdef SYNC_EDGE_CNT_EN
        , .EVT_CNT(EVT_CNT1)
`endif
    );

    typedef struct packed {
        logic        lvl;
        logic        vld;
        logic        ovf;
        logic [15:0] cnt;
    } st_t;

    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;
    st_t  stq[$];
    logic evq[$];

    // reference model state
    logic        m_level;
    int          m_run;
    logic        m_valid;
    logic        m_ovf;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0; m_run = 0; m_valid = 1'b0; m_ovf = 1'b0; m_cnt = 16'd0;
        stq.delete(); evq.delete();
    endtask

    // Drive one cycle of inputs and predict the outcome of the next rising edge.
    // Rule: a commit happens once L consecutive samples differ from LEVEL.
    task automatic step(input logic d, input logic en, input logic [3:0] len,
                        input logic rdy, input logic clr);
        int  l;
        bit  commit;
        bit  set;
        st_t e;
        @(negedge CLK);
        D_IN = d; EN = en; FILT_LEN = len; EVT_READY = rdy; OVF_CLR = clr;
        n_vec++;
        l = (len == 0) ? 1 : int'(len);
        commit = 0; set = 0;
        if (!en || d == m_level) m_run = 0;
        else begin
            m_run++;
            if (m_run >= l) begin commit = 1; m_run = 0; end
        end
        if (commit) begin
            if (!m_valid || rdy) begin m_valid = 1'b1; evq.push_back(d); end
            else set = 1;
            m_level = d;
            m_cnt++;
        end else if (m_valid && rdy) m_valid = 1'b0;
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        e.lvl = m_level; e.vld = m_valid; e.ovf = m_ovf; e.cnt = m_cnt;
        stq.push_back(e);
    endtask

    // state monitor: just after each rising edge
    always @(posedge CLK) begin
        st_t e;
        #1;
        if (stq.size() > 0) begin
            e = stq.pop_front();
            chk("level", {15'd0, LEVEL}, {15'd0, e.lvl});
            chk("evt_valid", {15'd0, EVT_VALID}, {15'd0, e.vld});
            chk("ovf", {15'd0, OVF}, {15'd0, e.ovf});
`ifdef SYNC_EDGE_CNT_EN
            chk("evt_cnt", EVT_CNT, e.cnt);
`endif
        end
    end

    // event monitor: a transfer is visible once inputs settle mid-cycle
    always @(negedge CLK) begin
        logic r;
        #1;
        if (RST_N && EVT_VALID && EVT_READY) begin
            if (evq.size() == 0) chk("evt_unexpected", 16'd1, 16'd0);
            else begin
                r = evq.pop_front();
                chk("evt_rise", {15'd0, EVT_RISE}, {15'd0, r});
            end
        end
    end

    task automatic do_reset_check();
        @(posedge CLK);
        #2;
        EN = 1'b0; EVT_READY = 1'b0; OVF_CLR = 1'b0;
        RST_N = 1'b0;
        #1;
        chk("rst_level", {15'd0, LEVEL}, 16'd0);
        chk("rst_valid", {15'd0, EVT_VALID}, 16'd0);
        chk("rst_rise", {15'd0, EVT_RISE}, 16'd0);
        chk("rst_ovf", {15'd0, OVF}, 16'd0);
        chk("rst_level_init1", {15'd0, LEVEL1}, 16'd1);
`ifdef SYNC_EDGE_CNT_EN
        chk("rst_cnt", EVT_CNT, 16'd0);
`endif
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("por_level", {15'd0, LEVEL}, 16'd0);
        chk("por_valid", {15'd0, EVT_VALID}, 16'd0);
        chk("por_ovf", {15'd0, OVF}, 16'd0);
        chk("por_level_init1", {15'd0, LEVEL1}, 16'd1);
        @(negedge CLK);
        RST_N = 1'b1;

        // FILT_LEN=3: held edge, then a 2-cycle glitch
        repeat (2) step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        repeat (5) step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        chk("glitch_level", {15'd0, LEVEL}, 16'd0);

        // FILT_LEN=0: toggle every 2 cycles
        for (int i = 0; i < 8; i++) begin
            step(i[0] ? 1'b0 : 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
            step(i[0] ? 1'b0 : 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
        end

        // overflow: rise held, fall dropped, set beats clear, then clear alone
        step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        chk("ovf_set_wins", {15'd0, OVF}, 16'd1);
        chk("ovf_hold_rise", {15'd0, EVT_RISE}, 16'd1);
        step(1'b1, 1'b1, 4'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0);

        // FILT_LEN=4: partial qualification, drop EN, restart, reset mid-QUAL
        repeat (2) step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 4'd4, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        chk("en_no_commit", {15'd0, LEVEL}, 16'd1);
        step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        do_reset_check();

        // randomized traffic
        begin
            logic d = 1'b0;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 2) == 0) d = ~d;
                step(d, ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            end
        end

`ifdef SYNC_EDGE_CNT_EN
        do_reset_check();
        for (int i = 0; i < 65537; i++)
            step(~m_level, 1'b1, 4'd1, (i % 5 == 0), 1'b0);
        step(m_level, 1'b1, 4'd1, 1'b0, 1'b0);
        @(posedge CLK);
        #2;
        chk("cnt_wrap", EVT_CNT, 16'd1);
`endif

        // drain and confirm every predicted event was delivered
        repeat (4) step(m_level, 1'b1, 4'd1, 1'b1, 1'b0);
        @(posedge CLK);
        #3;
        chk("evq_drained", 16'(evq.size()), 16'd0);
        chk("init1_level_end", {15'd0, LEVEL1}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
